// File: rtl/wallet_ctrl.sv
// ============================================================================
// wallet_ctrl
// ----------------------------------------------------------------------------
// Game wallet controller. Credits accrue on game ticks and saturate at a cap
// that grows with the player's level. Purchase and upgrade requests arrive over
// a req/ack handshake. Each transaction reports success on 'ok', which is
// returned together with the ack pulse. Upgrades are paid from the balance.
//
// Parameters
//   BAL_W     balance / cost width in bits
//   LVL_W     level width; the top level is 2^LVL_W-1
//   BASE_CAP  balance cap at level 0 (doubles per level, saturating)
//   INCOME    credits added per tick
//   UPG_BASE  upgrade price at level 0 (doubles per level, saturating)
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   tick      one-cycle game tick pulse
//   req       transaction request, held high until ack
//   op        0 = buy, 1 = upgrade; stable while req is high
//   cost      buy price; stable while req is high; ignored for upgrade
//   ack       one-cycle completion pulse
//   ok        result of the last transaction, held until the next ack
//   busy      transaction FSM is not idle
//   balance   current credits
//   cap       current balance cap (follows level one cycle later)
//   level     current level
//   maxed     level has reached the top level (follows level one cycle later)
//
// Build option
//   WALLET_INCOME_SCALE_EN  when defined, each tick adds INCOME << level
//                           instead of a flat INCOME.
// ============================================================================
module wallet_ctrl #(
    parameter int          BAL_W    = 16,
    parameter int          LVL_W    = 2,
    parameter int unsigned BASE_CAP = 256,
    parameter int unsigned INCOME   = 1,
    parameter int unsigned UPG_BASE = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             req,
    input  logic             op,
    input  logic [BAL_W-1:0] cost,
    output logic             ack,
    output logic             ok,
    output logic             busy,
    output logic [BAL_W-1:0] balance,
    output logic [BAL_W-1:0] cap,
    output logic [LVL_W-1:0] level,
    output logic             maxed
);

    // Wide enough to hold a 32-bit parameter shifted by the largest level
    // without losing bits, so saturation sees the true value.
    localparam int               WIDE_W  = 32 + BAL_W + (2 ** LVL_W);
    localparam logic [BAL_W-1:0] BAL_MAX = '1;
    localparam logic [LVL_W-1:0] MAX_LVL = '1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        RESP,
        WAIT_LOW
    } state_t;

    state_t           state;
    state_t           nextState;

    logic             opReg;
    logic [BAL_W-1:0] costReg;

    logic [BAL_W-1:0] capBase;
    logic [BAL_W-1:0] capTarget;
    logic [BAL_W-1:0] price;
    logic [BAL_W-1:0] charge;
    logic [BAL_W-1:0] afterCharge;
    logic [BAL_W-1:0] balNext;
    logic [BAL_W:0]   incWide;
    logic [BAL_W:0]   sumWide;
    logic             success;
    logic             commit;
    logic [LVL_W-1:0] levelNext;

    // Clamp a wide intermediate to the largest value the balance can hold.
    function automatic logic [BAL_W-1:0] satBal(input logic [WIDE_W-1:0] v);
        logic [BAL_W-1:0] r;
        if (v > {{(WIDE_W-BAL_W){1'b0}}, BAL_MAX}) begin
            r = BAL_MAX;
        end else begin
            r = v[BAL_W-1:0];
        end
        return r;
    endfunction

    // Level-dependent limits. The cap and upgrade price double with every
    // level and are shifted at full width before saturating, so a large
    // shift clamps to all-ones instead of wrapping to a small number.
    assign capBase   = satBal(WIDE_W'(BASE_CAP));
    assign capTarget = satBal(WIDE_W'(BASE_CAP) << level);
    assign price     = satBal(WIDE_W'(UPG_BASE) << level);

    // Per-tick income, one bit wider than the balance so the sum with the
    // balance cannot wrap before it is compared against the cap.
`ifdef WALLET_INCOME_SCALE_EN
    assign incWide = (BAL_W+1)'(INCOME) << level;
`else
    assign incWide = (BAL_W+1)'(INCOME);
`endif

    // Affordability decision for the latched transaction. The check uses the
    // balance as it stands before any income from a coincident tick. Upgrades
    // are refused at the top level even when the price could be paid.
    always_comb begin
        success = 1'b0;
        charge  = '0;
        if (opReg == 1'b0) begin
            success = (costReg <= balance);
            charge  = costReg;
        end else begin
            success = (level != MAX_LVL) && (price <= balance);
            charge  = price;
        end
    end

    assign commit = (state == EVAL) && success;

    // Next balance. The charge is taken first, then a tick adds income and
    // clamps to the current cap. Doing both in one update means a tick that
    // lands on the commit cycle is never dropped.
    always_comb begin
        afterCharge = balance;
        balNext     = balance;
        sumWide     = '0;
        if (commit) begin
            afterCharge = balance - charge;
        end
        sumWide = {1'b0, afterCharge} + incWide;
        if (tick) begin
            if (sumWide > {1'b0, cap}) begin
                balNext = cap;
            end else begin
                balNext = sumWide[BAL_W-1:0];
            end
        end else begin
            balNext = afterCharge;
        end
    end

    // A successful upgrade moves up exactly one level.
    always_comb begin
        levelNext = level;
        if (commit && opReg) begin
            levelNext = level + LVL_W'(1);
        end
    end

    // Transaction FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Transaction FSM next-state logic. Evaluation and response each take
    // one cycle. WAIT_LOW then holds until the requester drops req, so a
    // request held high cannot start a second transaction.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (req) begin
                    nextState = EVAL;
                end
            end
            EVAL:     nextState = RESP;
            RESP:     nextState = WAIT_LOW;
            WAIT_LOW: begin
                if (!req) begin
                    nextState = IDLE;
                end
            end
            default:  nextState = IDLE;
        endcase
    end

    // Transaction FSM outputs. These decode the state register only, so no
    // input reaches them combinationally.
    always_comb begin
        ack  = (state == RESP);
        busy = (state != IDLE);
    end

    // Wallet datapath registers. Cap and maxed are re-derived from the level
    // register every cycle, so they follow a level change one cycle later.
    // The request is latched while idle. The result is stored at the end of
    // EVAL so that ok changes together with the rise of ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            balance <= '0;
            level   <= '0;
            cap     <= capBase;
            maxed   <= 1'b0;
            ok      <= 1'b0;
            opReg   <= 1'b0;
            costReg <= '0;
        end else begin
            balance <= balNext;
            level   <= levelNext;
            cap     <= capTarget;
            maxed   <= (level == MAX_LVL);
            if ((state == IDLE) && req) begin
                opReg   <= op;
                costReg <= cost;
            end
            if (state == EVAL) begin
                ok <= success;
            end
        end
    end

endmodule

// File: tb/tb_wallet_ctrl.sv
// ============================================================================
// tb_wallet_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for wallet_ctrl with default parameters (BAL_W=16,
// LVL_W=2, BASE_CAP=256, INCOME=1, UPG_BASE=128). Inputs are driven 1 time
// unit after the rising edge. Outputs are sampled on the falling edge.
// ============================================================================
module tb_wallet_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        req;
    logic        op;
    logic [15:0] cost;
    logic        ack;
    logic        ok;
    logic        busy;
    logic [15:0] balance;
    logic [15:0] cap;
    logic [1:0]  level;
    logic        maxed;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state of the wallet, used to plan tick sequences.
    int mBal;
    int mLvl;
    int mCap;

    // Values captured by run_txn at fixed points of a transaction.
    logic        obsAckEval;
    logic        obsBusyEval;
    logic        obsAck;
    logic        obsOk;
    logic [15:0] obsBal;
    logic [1:0]  obsLvl;
    logic [15:0] obsCapResp;
    logic        obsAckAfter;
    logic [15:0] obsCap;
    logic        obsMaxed;
    logic        obsBusyIdle;

    wallet_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .req     (req),
        .op      (op),
        .cost    (cost),
        .ack     (ack),
        .ok      (ok),
        .busy    (busy),
        .balance (balance),
        .cap     (cap),
        .level   (level),
        .maxed   (maxed)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Credits per tick at a given level under the current build.
    function automatic int incFor(input int lvl);
`ifdef WALLET_INCOME_SCALE_EN
        return 1 << lvl;
`else
        return 1;
`endif
    endfunction

    // Pulse tick n times, one pulse every two cycles, and keep the
    // reference balance in step.
    task automatic pulse_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
            mBal = (mBal + incFor(mLvl) > mCap) ? mCap : mBal + incFor(mLvl);
        end
    endtask

    // Tick until the reference balance reaches the target.
    task automatic tick_until(input int target);
        int guard;
        guard = 0;
        while (mBal < target && guard < 5000) begin
            pulse_ticks(1);
            guard++;
        end
        vectors++;
        if (mBal < target) begin
            miscompares++;
            $display("[TB] FAIL tick_until: got %0d expected %0d", mBal, target);
        end
    endtask

    // Drive one complete transaction and capture outputs at each stage.
    // Optionally raises tick during the EVAL cycle.
    task automatic run_txn(input logic o, input logic [15:0] c, input logic tickEval);
        @(posedge clk);
        #1 req = 1'b1;
        op   = o;
        cost = c;
        @(posedge clk);
        #1 tick = tickEval;
        @(negedge clk);
        obsAckEval  = ack;
        obsBusyEval = busy;
        @(posedge clk);
        #1 tick = 1'b0;
        @(negedge clk);
        obsAck     = ack;
        obsOk      = ok;
        obsBal     = balance;
        obsLvl     = level;
        obsCapResp = cap;
        @(posedge clk);
        @(negedge clk);
        obsAckAfter = ack;
        obsCap      = cap;
        obsMaxed    = maxed;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obsBusyIdle = busy;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 1'b0;
        req  = 1'b0;
        op   = 1'b0;
        cost = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        mBal = 0;
        mLvl = 0;
        mCap = 256;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        tick = 1'b0;
        req  = 1'b0;
        op   = 1'b0;
        cost = '0;
        #3;
        vectors++;
        if (balance !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_balance: got %0d expected 0", balance); end
        vectors++;
        if (level !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
        vectors++;
        if (cap !== 16'd256) begin miscompares++; $display("[TB] FAIL reset_cap: got %0d expected 256", cap); end
        vectors++;
        if ({maxed, ack, ok, busy} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got maxed/ack/ok/busy=%b expected 0000", {maxed, ack, ok, busy});
        end
        do_reset();
    endtask

    task automatic test_income_cap();
        pulse_ticks(100);
        @(negedge clk);
        vectors++;
        if (balance !== 16'd100) begin miscompares++; $display("[TB] FAIL income_100: got %0d expected 100", balance); end
        pulse_ticks(200);
        @(negedge clk);
        vectors++;
        if (balance !== 16'd256) begin miscompares++; $display("[TB] FAIL income_sat: got %0d expected 256", balance); end
        vectors++;
        if (cap !== 16'd256 || level !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL income_cap_level: got cap=%0d level=%0d expected cap=256 level=0", cap, level);
        end
    endtask

    task automatic test_buy();
        run_txn(1'b0, 16'd56, 1'b0);
        vectors++;
        if (obsAckEval !== 1'b0 || obsBusyEval !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL buy_eval_stage: got ack=%b busy=%b expected ack=0 busy=1", obsAckEval, obsBusyEval);
        end
        vectors++;
        if (obsAck !== 1'b1 || obsOk !== 1'b1 || obsBal !== 16'd200) begin
            miscompares++;
            $display("[TB] FAIL buy_56: got ack=%b ok=%b bal=%0d expected ack=1 ok=1 bal=200", obsAck, obsOk, obsBal);
        end
        vectors++;
        if (obsAckAfter !== 1'b0 || obsBusyIdle !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL buy_ack_pulse: got ack=%b idle_busy=%b expected ack=0 idle_busy=0", obsAckAfter, obsBusyIdle);
        end

        run_txn(1'b0, 16'd150, 1'b0);
        vectors++;
        if (obsAck !== 1'b1 || obsOk !== 1'b1 || obsBal !== 16'd50) begin
            miscompares++;
            $display("[TB] FAIL buy_150: got ack=%b ok=%b bal=%0d expected ack=1 ok=1 bal=50", obsAck, obsOk, obsBal);
        end

        run_txn(1'b0, 16'd51, 1'b0);
        vectors++;
        if (obsAck !== 1'b1 || obsOk !== 1'b0 || obsBal !== 16'd50) begin
            miscompares++;
            $display("[TB] FAIL buy_51_refused: got ack=%b ok=%b bal=%0d expected ack=1 ok=0 bal=50", obsAck, obsOk, obsBal);
        end

        run_txn(1'b0, 16'd50, 1'b0);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL buy_exact: got ok=%b bal=%0d expected ok=1 bal=0", obsOk, obsBal);
        end

        run_txn(1'b0, 16'd0, 1'b0);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL buy_zero: got ok=%b bal=%0d expected ok=1 bal=0", obsOk, obsBal);
        end
        mBal = 0;
    endtask

    task automatic test_upgrade();
        tick_until(256);
        @(negedge clk);
        vectors++;
        if (balance !== 16'd256) begin miscompares++; $display("[TB] FAIL upg_fill: got %0d expected 256", balance); end

        run_txn(1'b1, 16'd0, 1'b0);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd128 || obsLvl !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL upg_l1: got ok=%b bal=%0d lvl=%0d expected ok=1 bal=128 lvl=1", obsOk, obsBal, obsLvl);
        end
        vectors++;
        if (obsCapResp !== 16'd256 || obsCap !== 16'd512 || obsMaxed !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL upg_l1_cap: got resp=%0d after=%0d maxed=%b expected resp=256 after=512 maxed=0",
                     obsCapResp, obsCap, obsMaxed);
        end
        mBal = 128; mLvl = 1; mCap = 512;

        tick_until(256);
        run_txn(1'b1, 16'd0, 1'b0);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd0 || obsLvl !== 2'd2 || obsCap !== 16'd1024) begin
            miscompares++;
            $display("[TB] FAIL upg_l2: got ok=%b bal=%0d lvl=%0d cap=%0d expected ok=1 bal=0 lvl=2 cap=1024",
                     obsOk, obsBal, obsLvl, obsCap);
        end
        mBal = 0; mLvl = 2; mCap = 1024;

        pulse_ticks(1);
        @(negedge clk);
        vectors++;
        if (balance !== 16'(incFor(2))) begin
            miscompares++;
            $display("[TB] FAIL income_l2: got %0d expected %0d", balance, incFor(2));
        end

        tick_until(512);
        run_txn(1'b1, 16'd0, 1'b0);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd0 || obsLvl !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL upg_l3: got ok=%b bal=%0d lvl=%0d expected ok=1 bal=0 lvl=3", obsOk, obsBal, obsLvl);
        end
        vectors++;
        if (obsMaxed !== 1'b1 || obsCap !== 16'd2048) begin
            miscompares++;
            $display("[TB] FAIL upg_l3_maxed: got maxed=%b cap=%0d expected maxed=1 cap=2048", obsMaxed, obsCap);
        end
        mBal = 0; mLvl = 3; mCap = 2048;

        tick_until(1024);
        run_txn(1'b1, 16'd0, 1'b0);
        vectors++;
        if (obsAck !== 1'b1 || obsOk !== 1'b0 || obsBal !== 16'(mBal) || obsLvl !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL upg_at_max: got ack=%b ok=%b bal=%0d lvl=%0d expected ack=1 ok=0 bal=%0d lvl=3",
                     obsAck, obsOk, obsBal, obsLvl, mBal);
        end
        vectors++;
        if (obsMaxed !== 1'b1 || obsCap !== 16'd2048) begin
            miscompares++;
            $display("[TB] FAIL upg_at_max_cap: got maxed=%b cap=%0d expected maxed=1 cap=2048", obsMaxed, obsCap);
        end
    endtask

    task automatic test_tick_coincident();
        do_reset();
        pulse_ticks(100);
        run_txn(1'b0, 16'd40, 1'b1);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd61) begin
            miscompares++;
            $display("[TB] FAIL tick_in_eval: got ok=%b bal=%0d expected ok=1 bal=61", obsOk, obsBal);
        end
        mBal = 61;

        tick_until(256);
        run_txn(1'b0, 16'd0, 1'b1);
        vectors++;
        if (obsOk !== 1'b1 || obsBal !== 16'd256) begin
            miscompares++;
            $display("[TB] FAIL tick_at_cap: got ok=%b bal=%0d expected ok=1 bal=256", obsOk, obsBal);
        end
    endtask

    task automatic test_reset_mid();
        logic sawAck;
        sawAck = 1'b0;
        @(posedge clk);
        #1 req = 1'b1;
        op   = 1'b0;
        cost = 16'd10;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ack !== 1'b0 || busy !== 1'b0 || ok !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_flags: got ack=%b busy=%b ok=%b expected 0 0 0", ack, busy, ok);
        end
        vectors++;
        if (balance !== 16'd0 || level !== 2'd0 || cap !== 16'd256) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_state: got bal=%0d lvl=%0d cap=%0d expected 0 0 256", balance, level, cap);
        end
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) sawAck = 1'b1;
        end
        vectors++;
        if (sawAck !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_no_ack: got ack seen=%b expected 0", sawAck);
        end
        mBal = 0; mLvl = 0; mCap = 256;
    endtask

    task automatic test_back_to_back();
        logic sawAck;
        logic sawIdle;
        sawAck  = 1'b0;
        sawIdle = 1'b0;
        pulse_ticks(5);
        @(posedge clk);
        #1 req = 1'b1;
        op   = 1'b0;
        cost = 16'd2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (ack !== 1'b1 || balance !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL hold_first: got ack=%b bal=%0d expected ack=1 bal=3", ack, balance);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack) sawAck = 1'b1;
            if (!busy) sawIdle = 1'b1;
        end
        vectors++;
        if (sawAck !== 1'b0 || sawIdle !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_req_high: got ack seen=%b idle seen=%b expected 0 0", sawAck, sawIdle);
        end
        req = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got busy=%b expected 0", busy);
        end
        run_txn(1'b0, 16'd3, 1'b0);
        vectors++;
        if (obsAck !== 1'b1 || obsOk !== 1'b1 || obsBal !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL second_txn: got ack=%b ok=%b bal=%0d expected 1 1 0", obsAck, obsOk, obsBal);
        end
        mBal = 0;
    endtask

    initial begin
        $display("[TB] wallet_ctrl directed test start");
        test_reset();
        test_income_cap();
        test_buy();
        test_upgrade();
        test_tick_coincident();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wallet_ctrl.md
# wallet_ctrl

Parametrised successor of the game wallet: accrues currency on game ticks, saturates at a level-dependent cap, and services purchase and upgrade requests through a req/ack handshake with an explicit success flag. Sits between the game-tick generator and the shop/upgrade logic in the clk domain. Width, cap, income and level count are parameters. Upgrades are paid from the balance rather than granted for free.

## Interface
- BAL_W, 16, balance/cost width (bits)
- LVL_W, 2, level width; MAX_LVL = 2^LVL_W-1
- BASE_CAP, 256, balance cap at level 0
- INCOME, 1, credits added per tick
- UPG_BASE, 128, upgrade cost at level 0
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick  in  1  game tick, one-cycle pulse synchronous to clk
- req  in  1  transaction request; held until ack
- op  in  1  0 = buy, 1 = upgrade; stable while req high
- cost  in  BAL_W  buy price; stable while req high; ignored for upgrade
- ack  out  1  one-cycle completion pulse
- ok  out  1  result of last transaction; valid with ack, held until next ack
- busy  out  1  FSM not in IDLE
- balance  out  BAL_W  current credits
- cap  out  BAL_W  current cap
- level  out  LVL_W  current level
- maxed  out  1  level == MAX_LVL

## Operation
- Reset values: balance 0, level 0, cap = min(BASE_CAP, 2^BAL_W-1), maxed 0, ack 0, ok 0, busy 0, FSM IDLE.
- cap = min(BASE_CAP << level, 2^BAL_W-1), computed at full width before saturation. Registered; updates on the cycle after a level change.
- Upgrade price = min(UPG_BASE << level, 2^BAL_W-1).
- Income: on tick, balance <= min(balance + inc, cap), where inc = INCOME. Sum is computed at BAL_W+1 bits, so the add never wraps.
- FSM states: IDLE -> EVAL when req=1. EVAL -> RESP unconditionally. RESP -> WAIT_LOW unconditionally. WAIT_LOW -> IDLE when req=0.
- IDLE: latches op and cost.
- EVAL, buy: succeeds iff cost <= balance; on success balance -= cost.
- EVAL, upgrade: succeeds iff !maxed and price <= balance; on success balance -= price and level += 1.
- EVAL, failure: no state change; the result bit is stored.
- RESP: ack=1 and ok = stored result.
- WAIT_LOW: ack=0. A new transaction cannot start until req has been seen low.
- Tick coincident with an EVAL commit: balance <= min(balance - charge + inc, cap). The affordability check uses the pre-tick balance. No tick is lost.
- Buy with cost = 0 always succeeds; balance is unchanged except for income.
- Upgrade at MAX_LVL: ok=0, nothing changes.
- Reset mid-transaction: FSM returns to IDLE, all outputs take reset values, and no ack is issued. The requester must re-issue.

## Timing
- req first seen high at edge n: EVAL at n+1, balance/level updated at n+2, ack=1 during cycle n+2 only.
- cap and maxed reflect the new level from n+3.
- Earliest next transaction: one cycle after req has been observed low in WAIT_LOW.
- Tick income applies at the edge following the tick, in every FSM state.
- No combinational path from inputs to outputs; all outputs registered.

## Configuration
- WALLET_INCOME_SCALE_EN defined: inc = INCOME << level, computed at BAL_W+1 bits before the cap clamp. Higher levels earn faster.
- Not defined: inc = INCOME at every level.

## Test plan
- Reset, then 300 ticks with BASE_CAP=256 -> balance rises 0..256 and holds at 256; cap=256, level=0.
- Balance 200, buy cost=150 -> ack 2 cycles after req, ok=1, balance 50. Then buy cost=51 -> ok=0, balance 50.
- Balance 256, upgrade -> ok=1, balance 128, level 1, cap 512. Repeat to level 3 -> maxed=1. Further upgrade -> ok=0, no change.
- Balance 100, buy cost=40 with tick in the EVAL cycle -> balance 61. Tick at cap with charge 0 -> balance remains at cap.
- Assert rst during EVAL -> no ack; balance 0, level 0, busy 0. Holding req high after ack -> no second ack until req drops.
- With WALLET_INCOME_SCALE_EN at level 2, INCOME=1 -> each tick adds 4.
